// File: rtl/hazard_pkg.sv
// Shared pipeline-control types: the hazard FSM states and the writeback-select
// encoding that marks a load. The decoder imports this package as well.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] RWSEL_MEM = 2'b01;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Asynchronous active-low reset clears it to zero.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline register enable/flush generation, halt draining FSM and
// saturating stall counter. Define HAZARD_STATS_EN to build the flush/load-use counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2:0]             rs_adr_id,
  input  logic [2:0]             rt_adr_id,
  input  logic                   rs_used_id,
  input  logic                   rt_used_id,
  input  logic                   regwrite_ex,
  input  logic [2:0]             regwrite_adr_ex,
  input  logic [1:0]             regwrite_dat_controll_ex,
  input  logic                   branch_taken_ex,
  input  logic                   is_halt_ex,
  input  logic                   is_halt_wb,
  input  logic                   mem_busy,
  output logic                   en_pc,
  output logic                   en_ifid,
  output logic                   en_idex,
  output logic                   en_exmem,
  output logic                   en_memwb,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [STALL_CNT_W-1:0] flush_cycles,
  output logic [STALL_CNT_W-1:0] load_use_events
);

  state_t state;
  state_t state_next;

  logic load_use;
  logic in_run;
  logic load_use_win;
  logic branch_flush;

  assign load_use = regwrite_ex
                  & (regwrite_dat_controll_ex == RWSEL_MEM)
                  & (regwrite_adr_ex != 3'd0)
                  & ((rs_used_id & (rs_adr_id == regwrite_adr_ex))
                   | (rt_used_id & (rt_adr_id == regwrite_adr_ex)));

  // Event qualifiers mirror the RUN priority order used below.
  assign in_run       = reset_n & (state == RUN);
  assign branch_flush = in_run & ~mem_busy & ~is_halt_ex & branch_taken_ex;
  assign load_use_win = in_run & ~mem_busy & ~is_halt_ex & ~branch_taken_ex & load_use;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    en_pc      = 1'b1;
    en_ifid    = 1'b1;
    en_idex    = 1'b1;
    en_exmem   = 1'b1;
    en_memwb   = 1'b1;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (reset_n) begin
      unique case (state)
        RUN: begin
          if (mem_busy) begin
            {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
          end else if (is_halt_ex) begin
            en_pc      = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_next = DRAIN;
          end else if (branch_taken_ex) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (load_use) begin
            // One bubble suffices: the load reaches MEM next cycle and forwards from there.
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
          end
        end
        DRAIN: begin
          if (mem_busy) begin
            {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
          end else begin
            en_pc      = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            if (is_halt_wb) begin
              state_next = HALTED;
            end
          end
        end
        HALTED: begin
          {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  assign halted = (state == HALTED);

  sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     ((in_run & mem_busy) | load_use_win),
    .count   (stall_cycles)
  );

`ifdef HAZARD_STATS_EN
  sat_counter #(.WIDTH(STALL_CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (branch_flush),
    .count   (flush_cycles)
  );

  sat_counter #(.WIDTH(STALL_CNT_W)) u_load_use_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (load_use_win),
    .count   (load_use_events)
  );
`else
  logic unused_stats;
  assign unused_stats    = branch_flush;
  assign flush_cycles    = '0;
  assign load_use_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: a 16-bit-counter instance and a 2-bit-counter
// instance share stimulus so saturation is observable alongside normal behaviour.
module tb_hazard_ctrl;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] rs_adr_id, rt_adr_id, regwrite_adr_ex;
  logic       rs_used_id, rt_used_id, regwrite_ex;
  logic [1:0] regwrite_dat_controll_ex;
  logic       branch_taken_ex, is_halt_ex, is_halt_wb, mem_busy;

  logic        en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, halted;
  logic [15:0] stall_cycles, flush_cycles, load_use_events;
  logic        en_pc2, en_ifid2, en_idex2, en_exmem2, en_memwb2, flush_ifid2, flush_idex2, halted2;
  logic [1:0]  stall_cycles2, flush_cycles2, load_use_events2;

  logic [4:0] en_all;
  logic [1:0] fl;
  assign en_all = {en_pc, en_ifid, en_idex, en_exmem, en_memwb};
  assign fl     = {flush_ifid, flush_idex};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.STALL_CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs_adr_id(rs_adr_id), .rt_adr_id(rt_adr_id),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .regwrite_ex(regwrite_ex), .regwrite_adr_ex(regwrite_adr_ex),
    .regwrite_dat_controll_ex(regwrite_dat_controll_ex),
    .branch_taken_ex(branch_taken_ex), .is_halt_ex(is_halt_ex),
    .is_halt_wb(is_halt_wb), .mem_busy(mem_busy),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .halted(halted),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
    .load_use_events(load_use_events)
  );

  hazard_ctrl #(.STALL_CNT_W(2)) dut_w2 (
    .clk(clk), .reset_n(reset_n),
    .rs_adr_id(rs_adr_id), .rt_adr_id(rt_adr_id),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .regwrite_ex(regwrite_ex), .regwrite_adr_ex(regwrite_adr_ex),
    .regwrite_dat_controll_ex(regwrite_dat_controll_ex),
    .branch_taken_ex(branch_taken_ex), .is_halt_ex(is_halt_ex),
    .is_halt_wb(is_halt_wb), .mem_busy(mem_busy),
    .en_pc(en_pc2), .en_ifid(en_ifid2), .en_idex(en_idex2),
    .en_exmem(en_exmem2), .en_memwb(en_memwb2),
    .flush_ifid(flush_ifid2), .flush_idex(flush_idex2), .halted(halted2),
    .stall_cycles(stall_cycles2), .flush_cycles(flush_cycles2),
    .load_use_events(load_use_events2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clr();
    rs_adr_id = 3'd0; rt_adr_id = 3'd0; rs_used_id = 1'b0; rt_used_id = 1'b0;
    regwrite_ex = 1'b0; regwrite_adr_ex = 3'd0; regwrite_dat_controll_ex = 2'b00;
    branch_taken_ex = 1'b0; is_halt_ex = 1'b0; is_halt_wb = 1'b0; mem_busy = 1'b0;
  endtask

  // EX-stage load writing register adr
  task automatic load_ex(input logic [2:0] adr);
    regwrite_ex = 1'b1; regwrite_dat_controll_ex = 2'b01; regwrite_adr_ex = adr;
  endtask

  // Advance past the next rising edge; inputs changed after this are stable well before the next one.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    reset_n = 1'b0;
    // Load-use pattern present during reset must not leak onto the enables.
    load_ex(3'd3); rs_adr_id = 3'd3; rs_used_id = 1'b1;
    #2;
    chk("rst_en", 32'(en_all), 32'h1F);
    chk("rst_flush", 32'(fl), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_stall", 32'(stall_cycles), 32'h0);
    cyc();
    clr();
    reset_n = 1'b1;

    // Load-use on rs: one bubble, stall 0 -> 1
    cyc(); load_ex(3'd3); rs_adr_id = 3'd3; rs_used_id = 1'b1; #1;
    chk("lu_rs_en", 32'(en_all), 32'h07);
    chk("lu_rs_flush", 32'(fl), 32'h1);
    chk("lu_rs_stall_before", 32'(stall_cycles), 32'h0);
    cyc(); clr(); #1;
    chk("lu_rs_stall_after", 32'(stall_cycles), 32'h1);
    chk("lu_rs_en_after", 32'(en_all), 32'h1F);

    // Load to r0, unused sources, non-load writeback: no stall
    load_ex(3'd0); rs_adr_id = 3'd0; rs_used_id = 1'b1; #1;
    chk("lu_r0_en", 32'(en_all), 32'h1F);
    load_ex(3'd4); rs_adr_id = 3'd4; rt_adr_id = 3'd4; rs_used_id = 1'b0; rt_used_id = 1'b0; #1;
    chk("lu_unused_en", 32'(en_all), 32'h1F);
    rt_used_id = 1'b1; regwrite_dat_controll_ex = 2'b00; #1;
    chk("nonload_en", 32'(en_all), 32'h1F);

    // Load-use on rt: stall 1 -> 2
    clr(); load_ex(3'd5); rt_adr_id = 3'd5; rt_used_id = 1'b1; #1;
    chk("lu_rt_en", 32'(en_all), 32'h07);
    cyc(); clr(); #1;
    chk("lu_rt_stall", 32'(stall_cycles), 32'h2);

    // Branch beats load-use
    load_ex(3'd3); rs_adr_id = 3'd3; rs_used_id = 1'b1; branch_taken_ex = 1'b1; #1;
    chk("br_lu_en", 32'(en_all), 32'h1F);
    chk("br_lu_flush", 32'(fl), 32'h3);
    cyc(); clr(); #1;
    chk("br_lu_stall", 32'(stall_cycles), 32'h2);
    chk("br_flush_cnt", 32'(flush_cycles), STATS ? 32'h1 : 32'h0);
    chk("br_lu_events", 32'(load_use_events), STATS ? 32'h2 : 32'h0);

    // mem_busy for 3 cycles over a load-use, then the bubble: stall 2 -> 6
    load_ex(3'd2); rs_adr_id = 3'd2; rs_used_id = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("busy_en_%0d", i), 32'(en_all), 32'h00);
      chk($sformatf("busy_flush_%0d", i), 32'(fl), 32'h0);
      cyc();
    end
    mem_busy = 1'b0; #1;
    chk("busy_then_bubble_en", 32'(en_all), 32'h07);
    chk("busy_then_bubble_fl", 32'(fl), 32'h1);
    cyc(); clr(); #1;
    chk("busy_stall", 32'(stall_cycles), 32'h6);
    chk("busy_stall_w2_sat", 32'(stall_cycles2), 32'h3);
    chk("busy_events", 32'(load_use_events), STATS ? 32'h3 : 32'h0);

    // Two more load-use events: 16-bit counter 8, 2-bit stays saturated
    for (int i = 0; i < 2; i++) begin
      load_ex(3'd6); rt_adr_id = 3'd6; rt_used_id = 1'b1;
      cyc(); clr();
    end
    #1;
    chk("more_lu_stall", 32'(stall_cycles), 32'h8);
    chk("more_lu_stall_w2", 32'(stall_cycles2), 32'h3);
    chk("more_lu_events_w2", 32'(load_use_events2), STATS ? 32'h3 : 32'h0);

    // Halt with concurrent branch: halt wins
    is_halt_ex = 1'b1; branch_taken_ex = 1'b1; #1;
    chk("halt_ex_en", 32'(en_all), 32'h0F);
    chk("halt_ex_flush", 32'(fl), 32'h3);
    cyc(); clr(); #1;
    chk("drain1_en", 32'(en_all), 32'h0F);
    chk("drain1_flush", 32'(fl), 32'h3);
    chk("drain1_halted", 32'(halted), 32'h0);
    cyc(); mem_busy = 1'b1; is_halt_wb = 1'b1; #1;
    chk("drain_busy_en", 32'(en_all), 32'h00);
    cyc(); mem_busy = 1'b0; #1;
    chk("drain_busy_nostall", 32'(stall_cycles), 32'h8);
    chk("drain_busy_held", 32'(halted), 32'h0);
    chk("drain2_en", 32'(en_all), 32'h0F);
    cyc(); clr(); #1;
    chk("halted_flag", 32'(halted), 32'h1);
    chk("halted_en", 32'(en_all), 32'h00);
    chk("halted_flush", 32'(fl), 32'h0);
    branch_taken_ex = 1'b1; load_ex(3'd3); rs_adr_id = 3'd3; rs_used_id = 1'b1; #1;
    chk("halted_br_en", 32'(en_all), 32'h00);
    chk("halted_br_flush", 32'(fl), 32'h0);
    cyc(); clr(); #1;
    chk("halted_stays", 32'(halted), 32'h1);
    chk("halted_stall", 32'(stall_cycles), 32'h8);
    chk("halted_flush_cnt", 32'(flush_cycles), STATS ? 32'h1 : 32'h0);

    // Async reset out of HALTED
    reset_n = 1'b0; #1;
    chk("rst_from_halted", 32'(halted), 32'h0);
    chk("rst_from_halted_stall", 32'(stall_cycles), 32'h0);
    cyc(); reset_n = 1'b1;

    // One stall, enter DRAIN, then async reset between edges
    cyc(); load_ex(3'd1); rs_adr_id = 3'd1; rs_used_id = 1'b1;
    cyc(); clr(); is_halt_ex = 1'b1;
    cyc(); clr(); #1;
    chk("pre_rst_stall", 32'(stall_cycles), 32'h1);
    chk("pre_rst_drain_en", 32'(en_all), 32'h0F);
    #2; reset_n = 1'b0; #1;
    chk("rst_drain_stall", 32'(stall_cycles), 32'h0);
    chk("rst_drain_stall_w2", 32'(stall_cycles2), 32'h0);
    chk("rst_drain_en", 32'(en_all), 32'h1F);
    chk("rst_drain_flush", 32'(fl), 32'h0);
    cyc(); reset_n = 1'b1;

    // Back in RUN: a load-use stalls again rather than draining
    cyc(); load_ex(3'd7); rs_adr_id = 3'd7; rs_used_id = 1'b1; #1;
    chk("post_rst_run_en", 32'(en_all), 32'h07);
    cyc(); clr(); #1;
    chk("post_rst_stall", 32'(stall_cycles), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
